// File: rtl/sequence_checker_pkg.sv
// Shared widths, addresses and FSM encoding for the sequence checker slice.
package sequence_checker_pkg;

    localparam int DIGIT_W         = 4;
    localparam int NUM_DIGITS      = 5;
    localparam int SEQ_W           = 20;
    localparam int ADDR_W          = 5;
    localparam int IDX_W           = 3;
    localparam int DEF_TIMEOUT_CYC = 1000;

    localparam logic [ADDR_W-1:0] SEQ_ADDR = '0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_READ     = 2'd1,
        ST_LATCH    = 2'd2,
        ST_WAIT_KEY = 2'd3
    } state_t;

endpackage

// File: rtl/sequence_checker_if.sv
// Controller/RAM/keypad bundle seen by the sequence checker.
interface sequence_checker_if;
    import sequence_checker_pkg::*;

    logic                start;
    logic [ADDR_W-1:0]   RAM_addr;
    logic                RAM_R;
    logic [SEQ_W-1:0]    RAM_data;
    logic                key_valid;
    logic [DIGIT_W-1:0]  key_digit;
    logic                busy;
    logic [IDX_W-1:0]    digit_idx;
    logic                correct;
    logic                wrong;
    logic                done;
    logic                timeout;

    // checker side
    modport slave (
        input  start, RAM_data, key_valid, key_digit,
        output RAM_addr, RAM_R, busy, digit_idx, correct, wrong, done, timeout
    );

    // controller / RAM / keypad side
    modport master (
        output start, RAM_data, key_valid, key_digit,
        input  RAM_addr, RAM_R, busy, digit_idx, correct, wrong, done, timeout
    );

endinterface

// File: rtl/sequence_checker_timer.sv
// Inactivity timer: counts enabled cycles, flags the last allowed idle cycle.
module seq_timeout_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] r_timer;
    logic             w_expire;

    assign w_expire = (r_timer == CNT_W'(TIMEOUT_CYC - 1));
    assign o_expire = w_expire;

    // Clear has priority; counting stops at the expiry value so it never wraps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_timer <= '0;
        end else if (i_clear) begin
            r_timer <= '0;
        end else if (i_enable && !w_expire) begin
            r_timer <= r_timer + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sequence_checker.sv
// Fetches the sequence word, then checks keypad entries digit by digit (MSB first).
module sequence_checker
    import sequence_checker_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    sequence_checker_if.slave bus
);

    state_t              r_state, w_state_next;
    logic                r_ram_r, w_ram_r_next;
    logic [ADDR_W-1:0]   r_ram_addr, w_ram_addr_next;
    logic                r_busy, w_busy_next;
    logic [IDX_W-1:0]    r_digit_idx, w_digit_idx_next;
    logic                r_correct, w_correct_next;
    logic                r_wrong, w_wrong_next;
    logic                r_done, w_done_next;
    logic                r_timeout, w_timeout_next;
    logic [SEQ_W-1:0]    r_seq, w_seq_next;

    logic                w_timer_clear;
    logic                w_timer_en;
    logic                w_expire;
    logic [DIGIT_W-1:0]  w_digits [NUM_DIGITS];
    logic [DIGIT_W-1:0]  w_exp_digit;

    seq_timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_en),
        .o_expire (w_expire)
    );

    // Split the latched word into digits, digit 0 being the most significant.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign w_digits[gi] = r_seq[SEQ_W-1-gi*DIGIT_W -: DIGIT_W];
    end

    // Select the digit currently expected; out-of-range indices read as zero.
    always_comb begin
        w_exp_digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digit_idx == IDX_W'(i)) begin
                w_exp_digit = w_digits[i];
            end
        end
    end

    // Next-state and registered-output logic; pulses default low every cycle.
    always_comb begin
        w_state_next     = r_state;
        w_ram_r_next     = 1'b0;
        w_ram_addr_next  = r_ram_addr;
        w_busy_next      = r_busy;
        w_digit_idx_next = r_digit_idx;
        w_correct_next   = 1'b0;
        w_wrong_next     = 1'b0;
        w_done_next      = 1'b0;
        w_timeout_next   = 1'b0;
        w_seq_next       = r_seq;
        w_timer_clear    = 1'b0;
        w_timer_en       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next    = ST_READ;
                    w_ram_r_next    = 1'b1;
                    w_ram_addr_next = SEQ_ADDR;
                    w_busy_next     = 1'b1;
                end
            end
            ST_READ: begin
                w_state_next = ST_LATCH;
            end
            ST_LATCH: begin
                w_seq_next       = bus.RAM_data;
                w_digit_idx_next = '0;
                w_timer_clear    = 1'b1;
                w_state_next     = ST_WAIT_KEY;
            end
            ST_WAIT_KEY: begin
                // A key on the expiring cycle takes priority over the timeout.
                if (bus.key_valid) begin
                    if (bus.key_digit == w_exp_digit) begin
                        w_correct_next = 1'b1;
                        if (r_digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
                            w_done_next      = 1'b1;
                            w_busy_next      = 1'b0;
                            w_digit_idx_next = '0;
                            w_state_next     = ST_IDLE;
                        end else begin
                            w_digit_idx_next = r_digit_idx + IDX_W'(1);
                            w_timer_clear    = 1'b1;
                        end
                    end else begin
                        w_wrong_next     = 1'b1;
                        w_busy_next      = 1'b0;
                        w_digit_idx_next = '0;
                        w_state_next     = ST_IDLE;
                    end
                end else begin
                    w_timer_en = 1'b1;
                    if (w_expire) begin
                        w_timeout_next   = 1'b1;
                        w_busy_next      = 1'b0;
                        w_digit_idx_next = '0;
                        w_state_next     = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_ram_r     <= 1'b0;
            r_ram_addr  <= '0;
            r_busy      <= 1'b0;
            r_digit_idx <= '0;
            r_correct   <= 1'b0;
            r_wrong     <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_seq       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_ram_r     <= w_ram_r_next;
            r_ram_addr  <= w_ram_addr_next;
            r_busy      <= w_busy_next;
            r_digit_idx <= w_digit_idx_next;
            r_correct   <= w_correct_next;
            r_wrong     <= w_wrong_next;
            r_done      <= w_done_next;
            r_timeout   <= w_timeout_next;
            r_seq       <= w_seq_next;
        end
    end

    assign bus.RAM_R     = r_ram_r;
    assign bus.RAM_addr  = r_ram_addr;
    assign bus.busy      = r_busy;
    assign bus.digit_idx = r_digit_idx;
    assign bus.correct   = r_correct;
    assign bus.wrong     = r_wrong;
    assign bus.done      = r_done;
    assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_sequence_checker.sv
// Randomised session-level check of sequence_checker against an outcome model.
module tb_sequence_checker;

    localparam int T = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [19:0] mem [32];
    logic [3:0]  s_keys [5];
    int          s_gaps [5];

    sequence_checker_if bus();

    sequence_checker #(
        .TIMEOUT_CYC (T)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural synchronous-read RAM: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.RAM_R) bus.RAM_data <= mem[bus.RAM_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare every output against the expected values for the edge just taken.
    task automatic expect_out(input string tag, input bit e_ram, input bit e_busy, input int e_idx,
                              input bit e_c, input bit e_w, input bit e_d, input bit e_t);
        check({tag, " flags(ram_r,busy,c,w,d,t)"},
              32'({bus.RAM_R, bus.busy, bus.correct, bus.wrong, bus.done, bus.timeout}),
              32'({e_ram, e_busy, e_c, e_w, e_d, e_t}));
        check({tag, " digit_idx"}, 32'(bus.digit_idx), 32'(e_idx));
        check({tag, " ram_addr"}, 32'(bus.RAM_addr), 32'(0));
    endtask

    // Fill the key table with the correct digits of a word, no idle gaps.
    task automatic load_ok(input logic [19:0] word);
        for (int i = 0; i < 5; i++) begin
            s_keys[i] = word[19-4*i -: 4];
            s_gaps[i] = 0;
        end
    endtask

    // IDLE cycles: keys are ignored, outputs stay quiet.
    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            bus.start     = 1'b0;
            bus.key_valid = 1'($urandom % 2);
            bus.key_digit = 4'($urandom);
            step();
            expect_out("idle", 0, 0, 0, 0, 0, 0, 0);
        end
        bus.key_valid = 1'b0;
    endtask

    // One start..end session. Outcome follows the rules: a key preceded by fewer
    // than T idle cycles is judged; the T-th consecutive idle cycle times out.
    task automatic run_session(input logic [19:0] word, input int abort_at);
        int          idle;
        bit          fin;
        string       res;
        logic [3:0]  exp_d;
        mem[0] = word;
        for (int a = 1; a < 32; a++) mem[a] = 20'($urandom);

        bus.start     = 1'b1;
        bus.key_valid = 1'($urandom % 2);
        bus.key_digit = 4'($urandom);
        step();
        expect_out("start", 1, 1, 0, 0, 0, 0, 0);
        bus.start     = 1'($urandom % 3 == 0);
        bus.key_valid = 1'($urandom % 2);
        step();
        expect_out("read", 0, 1, 0, 0, 0, 0, 0);
        bus.start     = 1'($urandom % 3 == 0);
        bus.key_valid = 1'($urandom % 2);
        step();
        expect_out("latch", 0, 1, 0, 0, 0, 0, 0);

        fin = 0;
        res = "done";
        for (int i = 0; i < 5 && !fin; i++) begin
            if (i == abort_at) begin
                bus.start     = 1'b0;
                bus.key_valid = 1'b0;
                rst           = 1'b0;
                for (int r = 0; r < 3; r++) begin
                    step();
                    expect_out("reset_mid", 0, 0, 0, 0, 0, 0, 0);
                end
                rst = 1'b1;
                res = "reset";
                fin = 1;
            end
            idle = 0;
            while (!fin && idle < s_gaps[i]) begin
                bus.key_valid = 1'b0;
                bus.start     = 1'($urandom % 4 == 0);
                bus.key_digit = 4'($urandom);
                step();
                idle++;
                if (idle == T) begin
                    expect_out("timeout", 0, 0, 0, 0, 0, 0, 1);
                    res = "timeout";
                    fin = 1;
                end else begin
                    expect_out("wait", 0, 1, i, 0, 0, 0, 0);
                end
            end
            if (!fin) begin
                bus.key_valid = 1'b1;
                bus.key_digit = s_keys[i];
                bus.start     = 1'($urandom % 4 == 0);
                step();
                exp_d = word[19-4*i -: 4];
                if (s_keys[i] == exp_d) begin
                    if (i == 4) begin
                        expect_out("key_last", 0, 0, 0, 1, 0, 1, 0);
                        fin = 1;
                    end else begin
                        expect_out("key_ok", 0, 1, i + 1, 1, 0, 0, 0);
                    end
                end else begin
                    expect_out("key_bad", 0, 0, 0, 0, 1, 0, 0);
                    res = "wrong";
                    fin = 1;
                end
            end
        end
        bus.start     = 1'b0;
        bus.key_valid = 1'b0;
        $display("session word=%05h gaps=%0d,%0d,%0d,%0d,%0d result=%s",
                 word, s_gaps[0], s_gaps[1], s_gaps[2], s_gaps[3], s_gaps[4], res);
    endtask

    initial begin
        logic [19:0] w;
        total = 0;
        bad   = 0;
        for (int a = 0; a < 32; a++) mem[a] = '0;
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_digit = '0;

        for (int r = 0; r < 3; r++) begin
            step();
            expect_out("reset", 0, 0, 0, 0, 0, 0, 0);
        end
        rst = 1'b1;
        idle_cycles(2);

        // full correct entry
        load_ok(20'h3A5C1);
        run_session(20'h3A5C1, -1);
        idle_cycles(2);

        // mismatch on second key
        load_ok(20'h3A5C1);
        s_keys[1] = 4'hB;
        run_session(20'h3A5C1, -1);
        idle_cycles(1);

        // timeout T cycles after the first key
        load_ok(20'h3A5C1);
        s_gaps[1] = T;
        run_session(20'h3A5C1, -1);
        idle_cycles(1);

        // key on the expiring cycle wins, then a back-to-back session
        load_ok(20'h3A5C1);
        s_gaps[1] = T - 1;
        run_session(20'h3A5C1, -1);
        load_ok(20'hFFFFF);
        run_session(20'hFFFFF, -1);
        idle_cycles(1);

        // reset in the middle of WAIT_KEY, then a normal session
        load_ok(20'h3A5C1);
        run_session(20'h3A5C1, 1);
        load_ok(20'h3A5C1);
        run_session(20'h3A5C1, -1);
        idle_cycles(1);

        // randomised sessions
        for (int n = 0; n < 40; n++) begin
            w = 20'($urandom);
            load_ok(w);
            for (int i = 0; i < 5; i++) begin
                if ($urandom % 8 == 0) s_keys[i] = 4'($urandom);
                if ($urandom % 10 == 0) s_gaps[i] = $urandom_range(T, T + 2);
                else                    s_gaps[i] = $urandom_range(0, T - 1);
            end
            run_session(w, ($urandom % 12 == 0) ? int'($urandom_range(0, 4)) : -1);
            idle_cycles($urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
